cheat_loader: RTL and testbench

CHEAT_LOADER -- requirements
Module: cheat_loader

---
 rtl/cheat_pkg.sv | 31 +++
 rtl/cheat_field_asm.sv | 43 ++++
 rtl/cheat_loader.sv | 160 ++++++++++++++++
 tb/tb_cheat_loader.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cheat_pkg.sv
// Shared definitions for the cheat loader and the code engine that consumes its code bus.
package cheat_pkg;

    localparam int unsigned CODE_W     = 129;
    localparam int unsigned STROBE_BIT = 128;
    localparam int unsigned FLAGS_LSB  = 96;
    localparam int unsigned ADDR_LSB   = 64;
    localparam int unsigned COMP_LSB   = 32;
    localparam int unsigned REPL_LSB   = 0;

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        COLLECT,
        STROBE_HI,
        STROBE_LO
    } cheat_state_e;

    // Bit position of record byte idx: fields arrive flags, addr, compare, replace, each little-endian.
    function automatic logic [6:0] byte_lsb(input logic [3:0] idx);
        logic [6:0] base;
        case (idx[3:2])
            2'd0:    base = 7'(FLAGS_LSB);
            2'd1:    base = 7'(ADDR_LSB);
            2'd2:    base = 7'(COMP_LSB);
            default: base = 7'(REPL_LSB);
        endcase
        return base + {2'b00, idx[1:0], 3'b000};
    endfunction

endpackage

// File: rtl/cheat_field_asm.sv
// Assembles 16 cheat-file bytes into one 128-bit record; rec_data already includes the byte on byte_in.
module cheat_field_asm
    import cheat_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         flush,
    input  logic         xfer,
    input  logic [7:0]   byte_in,
    output logic [3:0]   byte_cnt,
    output logic [127:0] rec_data
);

    logic [3:0]   cnt_q, cnt_d;
    logic [127:0] shreg_q, shreg_d;

    always_comb begin
        rec_data = shreg_q;
        rec_data[byte_lsb(cnt_q) +: 8] = byte_in;
        cnt_d    = cnt_q;
        shreg_d  = shreg_q;
        if (flush) begin
            cnt_d   = '0;
            shreg_d = '0;
        end else if (xfer) begin
            cnt_d   = cnt_q + 4'd1;
            shreg_d = rec_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            shreg_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
        end
    end

    assign byte_cnt = cnt_q;

endmodule

// File: rtl/cheat_loader.sv
// Streams a cheat file into 16-byte records and presents each one to the code engine
// with a strobe that is held high, then low, for STROBE_CYCLES cycles.
module cheat_loader
    import cheat_pkg::*;
#(
    parameter int unsigned MAX_CODES     = 32,
    parameter int unsigned STROBE_CYCLES = 2
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             dl_start,
    input  logic                             dl_valid,
    input  logic [7:0]                       dl_byte,
    input  logic                             dl_last,
    output logic                             dl_ready,
    output logic                             codes_reset,
    output logic [CODE_W-1:0]                code,
    output logic [$clog2(MAX_CODES+1)-1:0]   codes_loaded,
    output logic                             busy,
    output logic                             err_partial,
    output logic                             err_overflow
);

    localparam int unsigned CL_W  = $clog2(MAX_CODES + 1);
    localparam int unsigned TMR_W = (STROBE_CYCLES > 1) ? $clog2(STROBE_CYCLES) : 1;

    cheat_state_e           state_q, state_d;
    logic [TMR_W-1:0]       tmr_q, tmr_d;
    logic                   last_q, last_d;
    logic [STROBE_BIT-1:0]  code_q, code_d;
    logic                   strobe_q, strobe_d;
    logic [CL_W-1:0]        loaded_q, loaded_d;
    logic                   err_partial_q, err_partial_d;
    logic                   err_overflow_q, err_overflow_d;
    logic                   codes_reset_q, codes_reset_d;
    logic                   dl_ready_q, dl_ready_d;
    logic                   busy_q, busy_d;

    logic                   xfer;
    logic                   flush;
    logic                   tmr_end;
    logic [3:0]             byte_cnt;
    logic [127:0]           rec_data;

    // dl_start wins over a coincident byte, so that byte never reaches the assembler.
    assign xfer    = dl_valid && dl_ready_q && !dl_start;
    assign tmr_end = (tmr_q == TMR_W'(STROBE_CYCLES - 1));

    cheat_field_asm u_asm (
        .clk      (clk),
        .reset    (reset),
        .flush    (flush),
        .xfer     (xfer),
        .byte_in  (dl_byte),
        .byte_cnt (byte_cnt),
        .rec_data (rec_data)
    );

    always_comb begin
        state_d        = state_q;
        tmr_d          = tmr_q;
        last_d         = last_q;
        code_d         = code_q;
        loaded_d       = loaded_q;
        err_partial_d  = err_partial_q;
        err_overflow_d = err_overflow_q;
        flush          = dl_start;

        if (dl_start) begin
            state_d        = CLEAR;
            loaded_d       = '0;
            err_partial_d  = 1'b0;
            err_overflow_d = 1'b0;
        end else begin
            case (state_q)
                CLEAR: state_d = COLLECT;
                COLLECT: begin
                    if (xfer) begin
                        if (byte_cnt != 4'hF) begin
                            if (dl_last) begin
                                err_partial_d = 1'b1;
                                flush         = 1'b1;
                                state_d       = IDLE;
                            end
                        end else if (loaded_q == CL_W'(MAX_CODES)) begin
                            err_overflow_d = 1'b1;
                            if (dl_last) state_d = IDLE;
                        end else begin
                            code_d   = rec_data;
                            loaded_d = loaded_q + 1'b1;
                            last_d   = dl_last;
                            tmr_d    = '0;
                            state_d  = STROBE_HI;
                        end
                    end
                end
                STROBE_HI: begin
                    if (tmr_end) begin
                        tmr_d   = '0;
                        state_d = STROBE_LO;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                STROBE_LO: begin
                    if (tmr_end) begin
                        tmr_d   = '0;
                        state_d = last_q ? IDLE : COLLECT;
                    end else begin
                        tmr_d = tmr_q + 1'b1;
                    end
                end
                default: state_d = state_q;
            endcase
        end

        // Outputs are decoded from the next state so they are registered alongside it.
        strobe_d      = (state_d == STROBE_HI);
        dl_ready_d    = (state_d == COLLECT);
        busy_d        = (state_d != IDLE);
        codes_reset_d = (state_d == CLEAR);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= IDLE;
            tmr_q          <= '0;
            last_q         <= 1'b0;
            code_q         <= '0;
            strobe_q       <= 1'b0;
            loaded_q       <= '0;
            err_partial_q  <= 1'b0;
            err_overflow_q <= 1'b0;
            codes_reset_q  <= 1'b0;
            dl_ready_q     <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            tmr_q          <= tmr_d;
            last_q         <= last_d;
            code_q         <= code_d;
            strobe_q       <= strobe_d;
            loaded_q       <= loaded_d;
            err_partial_q  <= err_partial_d;
            err_overflow_q <= err_overflow_d;
            codes_reset_q  <= codes_reset_d;
            dl_ready_q     <= dl_ready_d;
            busy_q         <= busy_d;
        end
    end

    assign code         = {strobe_q, code_q};
    assign codes_loaded = loaded_q;
    assign dl_ready     = dl_ready_q;
    assign codes_reset  = codes_reset_q;
    assign busy         = busy_q;
    assign err_partial  = err_partial_q;
    assign err_overflow = err_overflow_q;

endmodule

// File: tb/tb_cheat_loader.sv
// Bench for cheat_loader: instance 0 uses default parameters, instance 1 has MAX_CODES=2.
module tb_cheat_loader;

    typedef logic [7:0] bq_t[$];
    typedef struct {
        logic [7:0]   b[16];
        logic [127:0] exp;
    } vec_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         vld_i[2];
    logic         lst_i[2];
    logic         st_i[2];
    logic [7:0]   byt_i[2];
    logic         rdy_o[2];
    logic         cr_o[2];
    logic         busy_o[2];
    logic         ep_o[2];
    logic         eo_o[2];
    logic [128:0] code_o[2];
    logic [5:0]   cl0;
    logic [1:0]   cl1;

    int errors = 0;
    int checks = 0;

    logic [127:0] capt0[$];
    logic [127:0] capt1[$];
    int           hi_run[2];
    int           lo_run[2];
    logic         prev_s[2];
    logic         seen[2];

    always #5 clk = ~clk;

    cheat_loader u_dut0 (
        .clk(clk), .reset(rst), .dl_start(st_i[0]), .dl_valid(vld_i[0]), .dl_byte(byt_i[0]),
        .dl_last(lst_i[0]), .dl_ready(rdy_o[0]), .codes_reset(cr_o[0]), .code(code_o[0]),
        .codes_loaded(cl0), .busy(busy_o[0]), .err_partial(ep_o[0]), .err_overflow(eo_o[0])
    );

    cheat_loader #(.MAX_CODES(2)) u_dut1 (
        .clk(clk), .reset(rst), .dl_start(st_i[1]), .dl_valid(vld_i[1]), .dl_byte(byt_i[1]),
        .dl_last(lst_i[1]), .dl_ready(rdy_o[1]), .codes_reset(cr_o[1]), .code(code_o[1]),
        .codes_loaded(cl1), .busy(busy_o[1]), .err_partial(ep_o[1]), .err_overflow(eo_o[1])
    );

    task automatic chk(input string name, input logic [128:0] act, input logic [128:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int cl_of(input int sel);
        return (sel == 0) ? int'(cl0) : int'(cl1);
    endfunction

    function automatic int capt_size(input int sel);
        return (sel == 0) ? capt0.size() : capt1.size();
    endfunction

    function automatic logic [127:0] capt_at(input int sel, input int idx);
        return (sel == 0) ? capt0[idx] : capt1[idx];
    endfunction

    // Reference: four little-endian 32-bit words, flags first, packed big-endian.
    function automatic logic [127:0] model_code(input bq_t q, input int base);
        logic [127:0] r;
        logic [31:0]  w;
        r = '0;
        for (int f = 0; f < 4; f++) begin
            w = '0;
            for (int k = 0; k < 4; k++) w = w | (32'(q[base + 4*f + k]) << (8*k));
            r = (r << 32) | 128'(w);
        end
        return r;
    endfunction

    // Strobe watcher: captures the code on every rising strobe, checks pulse shape and gap.
    always @(negedge clk) begin : mon
        logic s;
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                prev_s[d] = 1'b0;
                hi_run[d] = 0;
                lo_run[d] = 100;
                seen[d]   = 1'b0;
            end else begin
                s = code_o[d][128];
                if (s && !prev_s[d]) begin
                    if (seen[d]) chk("strobe_gap", 129'(lo_run[d] >= 2), 129'(1));
                    if (d == 0) capt0.push_back(code_o[d][127:0]);
                    else        capt1.push_back(code_o[d][127:0]);
                    seen[d]   = 1'b1;
                    hi_run[d] = 1;
                end else if (s) begin
                    hi_run[d]++;
                end else if (prev_s[d]) begin
                    chk("strobe_hi_len", 129'(hi_run[d]), 129'(2));
                    lo_run[d] = 1;
                end else if (lo_run[d] < 100) begin
                    lo_run[d]++;
                end
                if (s || lo_run[d] <= 2) chk("ready_in_strobe", 129'(rdy_o[d]), 129'(0));
                prev_s[d] = s;
            end
        end
    end

    task automatic pulse_start(input int sel);
        st_i[sel] = 1'b1;
        @(negedge clk);
        chk("codes_reset_on", 129'(cr_o[sel]), 129'(1));
        chk("clear_loaded", 129'(cl_of(sel)), 129'(0));
        chk("clear_errs", {127'(0), ep_o[sel], eo_o[sel]}, 129'(0));
        st_i[sel]  = 1'b0;
        vld_i[sel] = 1'b0;
        lst_i[sel] = 1'b0;
        @(negedge clk);
        chk("codes_reset_off", 129'(cr_o[sel]), 129'(0));
        chk("ready_collect", 129'(rdy_o[sel]), 129'(1));
    endtask

    task automatic send_byte(input int sel, input logic [7:0] b, input logic last);
        int n;
        n = 0;
        vld_i[sel] = 1'b1;
        byt_i[sel] = b;
        lst_i[sel] = last;
        while (!rdy_o[sel] && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (n >= 64) chk("ready_timeout", 129'(0), 129'(1));
        @(negedge clk);
    endtask

    task automatic release_in(input int sel);
        vld_i[sel] = 1'b0;
        lst_i[sel] = 1'b0;
    endtask

    task automatic wait_idle(input int sel);
        int n;
        n = 0;
        while (busy_o[sel] && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("idle_timeout", 129'(0), 129'(1));
    endtask

    task automatic download(input int sel, input bq_t q, input bit gaps);
        pulse_start(sel);
        for (int i = 0; i < q.size(); i++) begin
            send_byte(sel, q[i], i == q.size() - 1);
            if (gaps && $urandom_range(0, 3) == 0) begin
                release_in(sel);
                repeat ($urandom_range(1, 2)) @(negedge clk);
            end
        end
        release_in(sel);
        wait_idle(sel);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vt[3];
        bq_t  q;
        bq_t  fresh;
        int   n0;

        for (int d = 0; d < 2; d++) begin
            vld_i[d] = 1'b0; lst_i[d] = 1'b0; st_i[d] = 1'b0; byt_i[d] = '0;
        end

        vt[0].b   = '{8'h01, 8'h00, 8'h00, 8'h00, 8'h34, 8'h12, 8'h00, 8'h00,
                      8'hAA, 8'h00, 8'h00, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00};
        vt[0].exp = 128'h00000001_00001234_000000AA_00000055;
        vt[1].b   = '{8'h00, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07,
                      8'h08, 8'h09, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F};
        vt[1].exp = 128'h03020100_07060504_0B0A0908_0F0E0D0C;
        vt[2].b   = '{8'hEF, 8'hBE, 8'hAD, 8'hDE, 8'h78, 8'h56, 8'h34, 8'h12,
                      8'h00, 8'h00, 8'h00, 8'h80, 8'h01, 8'h00, 8'h00, 8'hFF};
        vt[2].exp = 128'hDEADBEEF_12345678_80000000_FF000001;

        repeat (2) @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("rst_code", code_o[d], 129'(0));
            chk("rst_loaded", 129'(cl_of(d)), 129'(0));
            chk("rst_flags", {123'(0), rdy_o[d], cr_o[d], busy_o[d], ep_o[d], eo_o[d], 1'b0}, 129'(0));
        end
        #1 rst = 1'b0;

        // Idle bytes are ignored.
        @(negedge clk);
        vld_i[0] = 1'b1;
        byt_i[0] = 8'h5A;
        repeat (3) begin
            @(negedge clk);
            chk("idle_ready", 129'(rdy_o[0]), 129'(0));
        end
        release_in(0);
        chk("idle_busy", 129'(busy_o[0]), 129'(0));

        // Single-record downloads with exact strobe waveform.
        for (int v = 0; v < 3; v++) begin
            pulse_start(0);
            for (int i = 0; i < 16; i++) send_byte(0, vt[v].b[i], i == 15);
            release_in(0);
            for (int c = 0; c < 4; c++) begin
                chk("strobe_shape", 129'(code_o[0][128]), 129'(c < 2));
                chk("busy_strobe", 129'(busy_o[0]), 129'(1));
                @(negedge clk);
            end
            chk("vec_code", 129'(code_o[0][127:0]), 129'(vt[v].exp));
            chk("vec_capture", 129'(capt0[$]), 129'(vt[v].exp));
            chk("vec_loaded", 129'(cl0), 129'(1));
            chk("vec_idle", 129'(busy_o[0]), 129'(0));
            chk("vec_errs", {127'(0), ep_o[0], eo_o[0]}, 129'(0));
        end

        // Three back-to-back records, valid held high throughout.
        q = {};
        repeat (48) q.push_back(8'($urandom));
        n0 = capt0.size();
        download(0, q, 1'b0);
        chk("b2b_count", 129'(capt0.size() - n0), 129'(3));
        for (int r = 0; r < 3; r++) chk("b2b_code", 129'(capt0[n0 + r]), 129'(model_code(q, 16*r)));
        chk("b2b_loaded", 129'(cl0), 129'(3));

        // Overflow with MAX_CODES=2.
        q = {};
        repeat (48) q.push_back(8'($urandom));
        n0 = capt1.size();
        download(1, q, 1'b0);
        chk("ovf_count", 129'(capt1.size() - n0), 129'(2));
        chk("ovf_flag", 129'(eo_o[1]), 129'(1));
        chk("ovf_loaded", 129'(cl1), 129'(2));
        chk("ovf_code_hold", 129'(code_o[1][127:0]), 129'(model_code(q, 16)));

        // dl_last on the 10th byte.
        q = {};
        repeat (10) q.push_back(8'($urandom));
        n0 = capt0.size();
        download(0, q, 1'b0);
        chk("part_count", 129'(capt0.size() - n0), 129'(0));
        chk("part_flag", 129'(ep_o[0]), 129'(1));
        chk("part_idle", 129'(busy_o[0]), 129'(0));

        // Asynchronous reset while the strobe is high.
        pulse_start(0);
        for (int i = 0; i < 16; i++) send_byte(0, vt[1].b[i], i == 15);
        release_in(0);
        chk("pre_rst_strobe", 129'(code_o[0][128]), 129'(1));
        #2 rst = 1'b1;
        #1;
        chk("async_rst_code", code_o[0], 129'(0));
        chk("async_rst_loaded", 129'(cl0), 129'(0));
        chk("async_rst_flags", {124'(0), rdy_o[0], cr_o[0], busy_o[0], ep_o[0], eo_o[0]}, 129'(0));
        @(negedge clk);
        #1 rst = 1'b0;

        // Restart after 7 bytes; the restart coincides with an offered byte that must be dropped.
        pulse_start(0);
        for (int i = 0; i < 7; i++) send_byte(0, 8'h11 + 8'(i), 1'b0);
        vld_i[0] = 1'b1;
        byt_i[0] = 8'hEE;
        pulse_start(0);
        fresh = {};
        repeat (16) fresh.push_back(8'($urandom));
        n0 = capt0.size();
        for (int i = 0; i < 16; i++) send_byte(0, fresh[i], i == 15);
        release_in(0);
        wait_idle(0);
        chk("restart_count", 129'(capt0.size() - n0), 129'(1));
        chk("restart_code", 129'(code_o[0][127:0]), 129'(model_code(fresh, 0)));
        chk("restart_loaded", 129'(cl0), 129'(1));

        // Randomized downloads against the file-level model.
        for (int it = 0; it < 30; it++) begin
            int sel, nrec, tail, maxc, exp_n;
            sel  = it % 2;
            nrec = $urandom_range(0, 4);
            tail = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 15) : 0;
            if (nrec == 0 && tail == 0) tail = 5;
            q = {};
            repeat (16*nrec + tail) q.push_back(8'($urandom));
            maxc  = (sel == 0) ? 32 : 2;
            exp_n = (nrec < maxc) ? nrec : maxc;
            n0    = capt_size(sel);
            download(sel, q, 1'b1);
            chk("rnd_count", 129'(capt_size(sel) - n0), 129'(exp_n));
            for (int r = 0; r < exp_n && r < capt_size(sel) - n0; r++)
                chk("rnd_code", 129'(capt_at(sel, n0 + r)), 129'(model_code(q, 16*r)));
            chk("rnd_loaded", 129'(cl_of(sel)), 129'(exp_n));
            chk("rnd_partial", 129'(ep_o[sel]), 129'(tail != 0));
            chk("rnd_overflow", 129'(eo_o[sel]), 129'(nrec > maxc));
            chk("rnd_idle", 129'(busy_o[sel]), 129'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
